// File: rtl/slow_clock_meter_if.sv
// Bus between a slow square-wave source and the slow_clock_meter.
// master drives sig_in and observes the measurement; slave is the meter.
interface slow_clock_meter_if #(
   parameter int CNT_W = 25
);
   logic             sig_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             period_valid;
   logic             lost;
   logic [15:0]      edge_count;

   modport master (
      output sig_in,
      input  period_out,
      input  high_out,
      input  period_valid,
      input  lost,
      input  edge_count
   );

   modport slave (
      input  sig_in,
      output period_out,
      output high_out,
      output period_valid,
      output lost,
      output edge_count
   );
endinterface

// File: rtl/slow_clock_meter.sv
// Measures period and high time of an asynchronous slow square wave in clk_in
// cycles, pulses period_valid per measurement and flags loss of the signal.
module slow_clock_meter #(
   parameter int CNT_W       = 25,
   parameter int TIMEOUT     = 30000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_in,
   input  logic               reset,
   slow_clock_meter_if.slave  bus,
   output logic [1:0]         o_state
);
   typedef enum logic [1:0] {
      WAIT_LOW   = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_prev;
   logic [CNT_W-1:0]       r_counter;
   logic [CNT_W-1:0]       r_high_latch;
   logic [CNT_W-1:0]       r_period;
   logic [CNT_W-1:0]       r_high;
   logic                   r_valid;
   logic                   r_lost;
   logic [15:0]            r_edge_count;

   logic w_s;
   logic w_primed;
   logic w_rise;
   logic w_fall;
   logic w_start;
   logic w_measure_done;
   logic w_timeout;

   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_primed = r_fill[SYNC_STAGES-1];
   assign w_rise   = w_s & ~r_prev;
   assign w_fall   = ~w_s & r_prev;

   // r_fill marks when the cleared synchroniser holds real samples again, so a
   // signal already high at reset release is not mistaken for a low level.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_sync <= '0;
         r_fill <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
         r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
         r_prev <= w_s;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state <= WAIT_LOW;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      w_start        = 1'b0;
      w_measure_done = 1'b0;
      w_timeout      = 1'b0;
      case (r_state)
         WAIT_LOW: begin
            if (w_primed && !w_s) begin
               w_next_state = WAIT_FIRST;
            end
         end
         WAIT_FIRST: begin
            if (w_rise) begin
               w_start      = 1'b1;
               w_next_state = MEASURE;
            end
         end
         MEASURE: begin
            // A rise on the timeout cycle still counts as a valid period.
            if (w_rise) begin
               w_measure_done = 1'b1;
            end else if (r_counter == LP_TIMEOUT) begin
               w_timeout    = 1'b1;
               w_next_state = WAIT_LOW;
            end
         end
         default: begin
            w_next_state = WAIT_LOW;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_counter    <= '0;
         r_high_latch <= '0;
         r_period     <= '0;
         r_high       <= '0;
         r_valid      <= 1'b0;
         r_lost       <= 1'b0;
         r_edge_count <= '0;
      end else begin
         r_valid <= w_measure_done;
         if (w_start || w_measure_done) begin
            r_counter    <= CNT_W'(1);
            r_edge_count <= r_edge_count + 16'd1;
         end else if (r_state == MEASURE && r_counter != LP_CNT_MAX) begin
            r_counter <= r_counter + CNT_W'(1);
         end
         if (r_state == MEASURE && w_fall) begin
            r_high_latch <= r_counter;
         end
         if (w_measure_done) begin
            r_period <= r_counter;
            r_high   <= r_high_latch;
            r_lost   <= 1'b0;
         end else if (w_timeout) begin
            r_lost <= 1'b1;
         end
      end
   end

   assign bus.period_out   = r_period;
   assign bus.high_out     = r_high;
   assign bus.period_valid = r_valid;
   assign bus.lost         = r_lost;
   assign bus.edge_count   = r_edge_count;
   assign o_state          = r_state;
endmodule

// File: doc/slow_clock_meter.md
Name: slow_clock_meter

Overview:
- Receiving end of the team's slow-clock dividers (4 Hz / 30 Hz style toggled outputs).
- Takes an asynchronous slow square wave, synchronises it to clk_in, and measures its period and high time in clk_in cycles.
- Reports each measurement with a one-cycle valid pulse and flags loss of the signal.
- Used to check divider outputs in-system and to drive seven-segment/LED debug displays.

Parameters:
- CNT_W, 25, width of the period/high-time counters. Default covers a 4 Hz toggle at 100 MHz: 25,000,002 cycles.
- TIMEOUT, 30000000, cycles in MEASURE without a rising edge before the signal is declared lost. Must be < 2^CNT_W - 1.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser. Must be ≥ 2.

Ports:
- clk_in  input  1  system clock, 100 MHz nominal.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous slow signal to measure.
- period_out  output  CNT_W  last measured period in clk_in cycles.
- high_out  output  CNT_W  high time belonging to period_out, in clk_in cycles.
- period_valid  output  1  one-cycle pulse when period_out/high_out update.
- lost  output  1  level; set on timeout, cleared by the next period_valid.
- edge_count  output  16  accepted rising edges, wraps modulo 2^16.

Behaviour:
- Reset: clk_in and reset are as already decided — reset is synchronous, active-high; clock is clk_in. Reset clears the synchroniser flops, prev, counter, high_latch, period_out, high_out, edge_count, period_valid and lost to 0, and sets state to WAIT_LOW. Reset mid-measurement discards the measurement in progress; no period_valid is produced.
- Synchroniser: sig_in passes through SYNC_STAGES flops; s = last stage, prev = s delayed by one cycle.
- rise = s & ~prev; fall = ~s & prev.
- States:
  - WAIT_LOW: go to WAIT_FIRST when s == 0. Prevents a signal already high at reset release from being taken as an edge.
  - WAIT_FIRST: on rise, counter <= 1, edge_count++, go to MEASURE. No outputs change.
  - MEASURE: counter <= counter + 1 every cycle, saturating at all-ones.
    - On fall: high_latch <= counter.
    - On rise: period_out <= counter, high_out <= high_latch, period_valid <= 1 for exactly one cycle, lost <= 0, edge_count++, counter <= 1, stay in MEASURE.
    - If counter == TIMEOUT with no rise that cycle: lost <= 1, go to WAIT_LOW. period_out/high_out keep their last values.
- Counting definition: period_out equals the number of clk_in cycles between two consecutive rise detections. high_out equals the number of cycles between a rise and the following fall.
- Latency: period_valid rises SYNC_STAGES + 1 clk_in edges after the first edge that samples the new sig_in high level.
- Simultaneous events:
  - rise in the same cycle as counter == TIMEOUT: the rise wins; a valid measurement with period_out = TIMEOUT is reported and lost is not set.
  - rise and fall cannot coincide.
- Wrap-around: edge_count wraps 0xFFFF -> 0x0000 without any flag.
- Outputs are registered; there are no combinational paths from sig_in.

Test Plan:
- Reset with sig_in low, then a square wave with 10-cycle period and 4 cycles high, clock-aligned: the first rise gives no pulse; each later rise gives period_valid one cycle wide, period_out = 10, high_out = 4; edge_count increments by 1 per rise.
- sig_in held high through reset release, falls after 20 cycles, then runs period 8 / high 3: no edge is accepted while high; first measurement is period_out = 8, high_out = 3.
- Override TIMEOUT = 50 and stop the waveform low after two periods of 10: lost = 1 exactly 50 cycles after the last rise and period_out stays 10. Restart at period 12: the first rise after restart gives no pulse; the second gives period_out = 12 and lost = 0.
- Override TIMEOUT = 20 and drive period exactly 20: period_valid fires with period_out = 20 and lost stays 0 (rise-wins rule).
- Assert reset for 1 cycle midway through a period-100 measurement: all outputs are 0 the next cycle; no stale period_valid; measurement resumes via WAIT_LOW.
- Apply 65,537 rising edges (period 4): edge_count ends at 1 after wrapping; every period_out = 4.
